// File: rtl/add32_accum_if.sv
// Operand stream, start/len command and result bundle for add32_accum.
interface add32_accum_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned HI_W  = 16
) ();
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             busy;
   logic             done;
   logic [31:0]      sum_lo;
   logic [HI_W-1:0]  sum_hi;
   logic             ovf;

   modport master (
      output start, len, in_valid, in_data,
      input  in_ready, busy, done, sum_lo, sum_hi, ovf
   );

   modport slave (
      input  start, len, in_valid, in_data,
      output in_ready, busy, done, sum_lo, sum_hi, ovf
   );
endinterface

// File: rtl/add32_accum.sv
// Multi-word accumulator: 32-bit carry-lookahead adder on the low word, carry-outs
// counted into an extended high word with a sticky wrap flag.
module add32_accum #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned HI_W  = 16
) (
   input  logic          clk,
   input  logic          rst,
   add32_accum_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      sum_lo_q, sum_lo_d;
   logic [HI_W-1:0]  sum_hi_q, sum_hi_d;
   logic             ovf_q, ovf_d;
   logic             in_ready, busy, done;

   logic [31:0] gen, prop, carry, sum;
   logic [7:0]  grp_g, grp_p;
   logic [8:0]  gc;
   logic        c32;

   // Two-level lookahead: 4-bit groups, group carries chained, carry-in fixed at 0.
   always_comb begin
      gen   = sum_lo_q & bus.in_data;
      prop  = sum_lo_q ^ bus.in_data;
      grp_g = '0;
      grp_p = '0;
      gc    = '0;
      carry = '0;
      for (int k = 0; k < 8; k++) begin
         grp_g[k] = gen[4*k+3] | (prop[4*k+3] & gen[4*k+2])
                  | (&prop[4*k+2 +: 2] & gen[4*k+1]) | (&prop[4*k+1 +: 3] & gen[4*k]);
         grp_p[k] = &prop[4*k +: 4];
      end
      for (int k = 0; k < 8; k++) begin
         gc[k+1] = grp_g[k] | (grp_p[k] & gc[k]);
      end
      for (int k = 0; k < 8; k++) begin
         carry[4*k]   = gc[k];
         carry[4*k+1] = gen[4*k] | (prop[4*k] & gc[k]);
         carry[4*k+2] = gen[4*k+1] | (prop[4*k+1] & gen[4*k]) | (&prop[4*k +: 2] & gc[k]);
         carry[4*k+3] = gen[4*k+2] | (prop[4*k+2] & gen[4*k+1])
                      | (&prop[4*k+1 +: 2] & gen[4*k]) | (&prop[4*k +: 3] & gc[k]);
      end
      sum = prop ^ carry;
      c32 = gc[8];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sum_lo_d = sum_lo_q;
      sum_hi_d = sum_hi_q;
      ovf_d    = ovf_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               sum_lo_d = '0;
               sum_hi_d = '0;
               ovf_d    = 1'b0;
               cnt_d    = bus.len;
               state_d  = (bus.len == '0) ? StDone : StAcc;
            end
         end
         StAcc: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (bus.in_valid) begin
               sum_lo_d = sum;
               sum_hi_d = sum_hi_q + HI_W'(c32);
               ovf_d    = ovf_q | (c32 & (&sum_hi_q));
               cnt_d    = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = StDone;
            end
         end
         StDone: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sum_lo_q <= '0;
         sum_hi_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sum_lo_q <= sum_lo_d;
         sum_hi_q <= sum_hi_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.sum_lo   = sum_lo_q;
   assign bus.sum_hi   = sum_hi_q;
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_add32_accum.sv
// Bench for add32_accum: two instances (HI_W=16 and HI_W=2) share one stimulus stream;
// expected results come from whole-sum integer arithmetic and are checked on done.
module tb_add32_accum;

   localparam int unsigned CNT_W = 8;

   typedef struct {
      logic [31:0] lo;
      logic [15:0] hi16;
      logic        ovf16;
      logic [1:0]  hi2;
      logic        ovf2;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [31:0] wq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   add32_accum_if #(.CNT_W(CNT_W), .HI_W(16)) if0 ();
   add32_accum_if #(.CNT_W(CNT_W), .HI_W(2))  if1 ();

   assign if1.start    = if0.start;
   assign if1.len      = if0.len;
   assign if1.in_valid = if0.in_valid;
   assign if1.in_data  = if0.in_data;

   add32_accum #(.CNT_W(CNT_W), .HI_W(16)) dut (.clk(clk), .rst(rst), .bus(if0));
   add32_accum #(.CNT_W(CNT_W), .HI_W(2))  dut2 (.clk(clk), .rst(rst), .bus(if1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (if0.done === 1'b1 || if1.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=%b/%b expected none", if0.done, if1.done);
         end else begin
            mon_e = exp_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            chk("done_both", {if0.done, if1.done}, 2'b11);
            chk("sum_lo", if0.sum_lo, mon_e.lo);
            chk("sum_lo_w2", if1.sum_lo, mon_e.lo);
            chk("sum_hi16", if0.sum_hi, mon_e.hi16);
            chk("ovf16", if0.ovf, mon_e.ovf16);
            chk("sum_hi2", if1.sum_hi, mon_e.hi2);
            chk("ovf2", if1.ovf, mon_e.ovf2);
            chk("done_busy", if0.busy, 1'b1);
            chk("done_in_ready", if0.in_ready, 1'b0);
         end
      end
   end

   task automatic check_reset_state();
      chk("rst_sum_lo", {if0.sum_lo, if1.sum_lo}, 64'h0);
      chk("rst_sum_hi", {if0.sum_hi, if1.sum_hi}, 18'h0);
      chk("rst_flags", {if0.ovf, if1.ovf, if0.busy, if1.busy, if0.done, if1.done,
                        if0.in_ready, if1.in_ready}, 8'h0);
   endtask

   // Accumulates wq; bubbles of gmin..gmax cycles carry junk data and ignored start/len.
   task automatic run_acc(input int gmin, input int gmax);
      exp_t            e;
      longint unsigned tot;
      longint unsigned car;
      int              n;
      n   = wq.size();
      tot = 0;
      foreach (wq[i]) tot += {32'h0, wq[i]};
      car     = tot >> 32;
      e.lo    = tot[31:0];
      e.hi16  = car[15:0];
      e.ovf16 = (car >= 64'd65536);
      e.hi2   = car[1:0];
      e.ovf2  = (car >= 64'd4);
      if0.start = 1'b1;
      if0.len   = n[CNT_W-1:0];
      @(posedge clk); #1;
      if0.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         int g;
         g = $urandom_range(gmax, gmin);
         repeat (g) begin
            if0.in_valid = 1'b0;
            if0.in_data  = $urandom;
            if0.start    = 1'($urandom_range(1, 0));
            if0.len      = CNT_W'($urandom);
            @(negedge clk);
            chk("bubble_busy", if0.busy, 1'b1);
            chk("bubble_no_done", if0.done, 1'b0);
            @(posedge clk); #1;
         end
         if0.start    = 1'b0;
         if0.in_valid = 1'b1;
         if0.in_data  = wq[i];
         @(negedge clk);
         chk("in_ready", if0.in_ready, 1'b1);
         @(posedge clk); #1;
      end
      if0.in_valid = 1'b0;
      e.cyc = cyc;
      exp_q.push_back(e);
      if0.start = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      if0.start = 1'b0;
      repeat ($urandom_range(2, 0)) begin
         @(negedge clk);
         chk("hold_sum_lo", if0.sum_lo, e.lo);
         chk("idle_busy", if0.busy, 1'b0);
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [31:0] rand_word();
      if ($urandom_range(3, 0) == 0) return 32'hFFFF_FFFF - 32'($urandom_range(15, 0));
      return $urandom;
   endfunction

   initial begin
      if0.start    = 1'b0;
      if0.len      = '0;
      if0.in_valid = 1'b0;
      if0.in_data  = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_state();
      @(posedge clk); #1;

      wq = {32'd1, 32'd2, 32'd3};
      run_acc(0, 0);
      wq = {32'hFFFF_FFFF, 32'h0000_0001};
      run_acc(0, 0);
      wq = {};
      run_acc(0, 0);
      wq = {32'd10, 32'd20, 32'd30, 32'd40};
      run_acc(1, 3);
      wq = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      run_acc(0, 1);

      // Abort mid-accumulation; in_valid stays high to show reset dominates.
      if0.start = 1'b1;
      if0.len   = 8'd4;
      @(posedge clk); #1;
      if0.start = 1'b0;
      repeat (2) begin
         if0.in_valid = 1'b1;
         if0.in_data  = $urandom | 32'h1;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if0.in_valid = 1'b0;
      @(negedge clk);
      check_reset_state();
      @(posedge clk); #1;
      wq = {32'd7};
      run_acc(0, 0);

      for (int r = 0; r < 20; r++) begin
         int n;
         n  = $urandom_range(12, 0);
         wq = {};
         for (int i = 0; i < n; i++) wq.push_back(rand_word());
         run_acc(0, 2);
      end
      wq = {};
      for (int i = 0; i < 200; i++) wq.push_back(rand_word());
      run_acc(0, 0);
      wq = {};
      for (int i = 0; i < 255; i++) wq.push_back(32'hFFFF_FFFF);
      run_acc(0, 0);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL missing_done: got %0d outstanding results expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
